vga_timing_gen: RTL

//  640x480@60 raster timing generator clocked at the pixel rate (vga_clk, 25 MHz).

---
 rtl/vga_timing_gen_if.sv | 33 +++
 rtl/vga_timing_gen.sv | 129 ++++++++++++
 2 files changed

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from vga_timing_gen to the pixel pipeline and connector.
// VGA_TIMING_TEST_PATTERN_EN adds the colour-bar test pattern signals.
interface vga_timing_gen_if;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       blank;
  logic       blank_dly;
  logic       hs;
  logic       vs;
  logic       frame_start;
  logic [7:0] frame_count;
`ifdef VGA_TIMING_TEST_PATTERN_EN
  logic [3:0] tp_red;
  logic [3:0] tp_green;
  logic [3:0] tp_blue;
`endif

  modport master (
    output DrawX, DrawY, blank, blank_dly,
    output hs, vs, frame_start, frame_count
`ifdef VGA_TIMING_TEST_PATTERN_EN
    , output tp_red, tp_green, tp_blue
`endif
  );

  modport slave (
    input DrawX, DrawY, blank, blank_dly,
    input hs, vs, frame_start, frame_count
`ifdef VGA_TIMING_TEST_PATTERN_EN
    , input tp_red, tp_green, tp_blue
`endif
  );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster counters with delayed hs/vs/blank_dly.
// VGA_TIMING_TEST_PATTERN_EN adds a registered 8-bar colour pattern.
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int SYNC_DELAY = 2
) (
  input  logic         vga_clk,
  input  logic         reset_n,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL =
    H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL =
    V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_MAX = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS = 10'(V_VISIBLE);
  localparam logic [9:0] HS_LO =
    10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_HI =
    10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_LO =
    10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_HI =
    10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic [9:0] hc;
  logic [9:0] vc;
  logic [7:0] fc;
  logic       blank_raw;
  logic       hs_raw;
  logic       vs_raw;

  // Reset parks at the last pixel so the first edge lands on (0,0).
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hc <= H_MAX;
      vc <= V_MAX;
      fc <= 8'hFF;
    end else if (hc == H_MAX) begin
      hc <= '0;
      if (vc == V_MAX) begin
        vc <= '0;
        fc <= fc + 8'd1;
      end else begin
        vc <= vc + 10'd1;
      end
    end else begin
      hc <= hc + 10'd1;
    end
  end

  always_comb begin
    blank_raw = (hc < H_VIS) && (vc < V_VIS);
    hs_raw    = !((hc >= HS_LO) && (hc <= HS_HI));
    vs_raw    = !((vc >= VS_LO) && (vc <= VS_HI));
  end

  assign vga.DrawX       = hc;
  assign vga.DrawY       = vc;
  assign vga.blank       = blank_raw;
  assign vga.frame_start = (hc == '0) && (vc == '0);
  assign vga.frame_count = fc;

  generate
    if (SYNC_DELAY == 0) begin : g_nodly
      assign vga.hs        = hs_raw;
      assign vga.vs        = vs_raw;
      assign vga.blank_dly = blank_raw;
    end else begin : g_dly
      logic [SYNC_DELAY-1:0] hs_sr;
      logic [SYNC_DELAY-1:0] vs_sr;
      logic [SYNC_DELAY-1:0] bl_sr;

      always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
          hs_sr <= '1;
          vs_sr <= '1;
          bl_sr <= '0;
        end else begin
          hs_sr[0] <= hs_raw;
          vs_sr[0] <= vs_raw;
          bl_sr[0] <= blank_raw;
          for (int i = 1; i < SYNC_DELAY; i++) begin
            hs_sr[i] <= hs_sr[i-1];
            vs_sr[i] <= vs_sr[i-1];
            bl_sr[i] <= bl_sr[i-1];
          end
        end
      end

      assign vga.hs        = hs_sr[SYNC_DELAY-1];
      assign vga.vs        = vs_sr[SYNC_DELAY-1];
      assign vga.blank_dly = bl_sr[SYNC_DELAY-1];
    end
  endgenerate

`ifdef VGA_TIMING_TEST_PATTERN_EN
  logic [2:0] bar;
  assign bar = 3'(hc / 10'd80);

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      vga.tp_red   <= '0;
      vga.tp_green <= '0;
      vga.tp_blue  <= '0;
    end else if (blank_raw) begin
      vga.tp_red   <= {4{bar[2]}};
      vga.tp_green <= {4{bar[1]}};
      vga.tp_blue  <= {4{bar[0]}};
    end else begin
      vga.tp_red   <= '0;
      vga.tp_green <= '0;
      vga.tp_blue  <= '0;
    end
  end
`endif

endmodule
